// File: rtl/stack_store_writer_pkg.sv
// stack_store_writer_pkg
//   Shared widths, stack page, write-op and FSM state encodings for the CPU write sequencer,
//   plus small helpers that describe each op (byte count, whether it moves SP).
package stack_store_writer_pkg;

    localparam int unsigned REG_WIDTH  = 8;
    localparam int unsigned ADDR_WIDTH = 16;

    // Page added to SP to form the stack address.
    localparam logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100;

    typedef enum logic [1:0] {
        WOP_STORE    = 2'd0,
        WOP_PUSH1    = 2'd1,
        WOP_PUSH_PC  = 2'd2,
        WOP_PUSH_IRQ = 2'd3
    } wop_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWrite  = 2'd1,
        StFinish = 2'd2
    } state_e;

    // Number of bytes written by an op.
    function automatic logic [1:0] wop_len(input wop_e op);
        case (op)
            WOP_PUSH_PC:  return 2'd2;
            WOP_PUSH_IRQ: return 2'd3;
            default:      return 2'd1;
        endcase
    endfunction

    // Every op other than a plain store goes through the stack and moves SP.
    function automatic logic wop_is_push(input wop_e op);
        return op != WOP_STORE;
    endfunction

endpackage

// File: rtl/stack_store_writer_if.sv
// stack_store_writer_if
//   Memory write bus between the write sequencer and the memory/bus mux.
//   Signals:
//     mem_we     write strobe (held until mem_ready)
//     mem_addr   write address
//     mem_wdata  write data
//     mem_ready  memory accepted the current write this cycle
//   Modports:
//     master  write sequencer side (drives strobe/address/data, samples ready)
//     slave   memory side
interface stack_store_writer_if;
    import stack_store_writer_pkg::*;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]  mem_wdata;
    logic                  mem_ready;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready
    );

endinterface

// File: rtl/stack_store_writer.sv
// stack_store_writer
//   Sequences all CPU memory writes: single-byte stores, single-byte pushes and multi-byte
//   pushes (return address, return address plus status). Owns SP arithmetic for pushes and
//   the write handshake with memory.
//   Ports:
//     phi1       clock, all state changes on the rising edge
//     reset_n    synchronous active-low reset
//     start      request strobe, only sampled while idle
//     op         0=STORE, 1=PUSH1, 2=PUSH_PC, 3=PUSH_IRQ
//     addr_in    target address for STORE
//     data_in    byte for STORE/PUSH1
//     pc_in      return address for PUSH_PC/PUSH_IRQ
//     status_in  P register for PUSH_IRQ
//     sp_in      current stack pointer
//     busy       request in progress
//     done       one-cycle completion pulse
//     sp_out     updated stack pointer
//     sp_we      one-cycle SP update pulse, with done, push ops only
//     mem        memory write bus (master side)
module stack_store_writer
    import stack_store_writer_pkg::*;
(
    input  logic                  phi1,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [REG_WIDTH-1:0]  data_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [REG_WIDTH-1:0]  status_in,
    input  logic [REG_WIDTH-1:0]  sp_in,
    output logic                  busy,
    output logic                  done,
    output logic [REG_WIDTH-1:0]  sp_out,
    output logic                  sp_we,
    stack_store_writer_if.master  mem
);

    // Byte k of a request: PCH, PCL, P for return-address pushes, the data byte otherwise.
    function automatic logic [REG_WIDTH-1:0] sel_byte(
        input wop_e                  o,
        input logic [1:0]            k,
        input logic [REG_WIDTH-1:0]  d,
        input logic [ADDR_WIDTH-1:0] pc,
        input logic [REG_WIDTH-1:0]  p
    );
        if (o == WOP_PUSH_PC || o == WOP_PUSH_IRQ) begin
            case (k)
                2'd0:    return pc[ADDR_WIDTH-1 -: REG_WIDTH];
                2'd1:    return pc[REG_WIDTH-1:0];
                default: return p;
            endcase
        end
        return d;
    endfunction

    // Address of byte k: the plain target for a store, else page 1 at (sp - k) mod 256.
    function automatic logic [ADDR_WIDTH-1:0] write_addr(
        input wop_e                  o,
        input logic [1:0]            k,
        input logic [ADDR_WIDTH-1:0] a,
        input logic [REG_WIDTH-1:0]  sp
    );
        logic [REG_WIDTH-1:0] slot;
        // Kept at SP width so the subtraction wraps inside the stack page.
        slot = sp - REG_WIDTH'(k);
        if (o == WOP_STORE) begin
            return a;
        end
        return STACK_BASE + {{(ADDR_WIDTH - REG_WIDTH){1'b0}}, slot};
    endfunction

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    wop_e                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0]  data_q, data_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [REG_WIDTH-1:0]  status_q, status_d;
    logic [REG_WIDTH-1:0]  sp_q, sp_d;

    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [REG_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                  done_q, done_d;
    logic                  sp_we_q, sp_we_d;
    logic [REG_WIDTH-1:0]  sp_out_q, sp_out_d;

    wop_e                  op_in;
    logic                  last_byte;
    logic [1:0]            idx_nxt;

    assign op_in     = wop_e'(op);
    assign last_byte = (idx_q == (wop_len(op_q) - 2'd1));
    assign idx_nxt   = idx_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        pc_d        = pc_q;
        status_d    = status_q;
        sp_d        = sp_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        sp_we_d     = 1'b0;
        sp_out_d    = sp_out_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    // Snapshot the request; later input changes must not leak in.
                    op_d        = op_in;
                    addr_d      = addr_in;
                    data_d      = data_in;
                    pc_d        = pc_in;
                    status_d    = status_in;
                    sp_d        = sp_in;
                    idx_d       = 2'd0;
                    state_d     = StWrite;
                    // Byte 0 is computed from the live inputs so it is on the bus next cycle.
                    mem_we_d    = 1'b1;
                    mem_addr_d  = write_addr(op_in, 2'd0, addr_in, sp_in);
                    mem_wdata_d = sel_byte(op_in, 2'd0, data_in, pc_in, status_in);
                end
            end

            StWrite: begin
                // Without mem_ready everything holds: unlimited wait states.
                if (mem.mem_ready) begin
                    if (last_byte) begin
                        state_d  = StFinish;
                        mem_we_d = 1'b0;
                        done_d   = 1'b1;
                        if (wop_is_push(op_q)) begin
                            sp_we_d  = 1'b1;
                            sp_out_d = sp_q - REG_WIDTH'(wop_len(op_q));
                        end
                    end else begin
                        idx_d       = idx_nxt;
                        mem_addr_d  = write_addr(op_q, idx_nxt, addr_q, sp_q);
                        mem_wdata_d = sel_byte(op_q, idx_nxt, data_q, pc_q, status_q);
                    end
                end
            end

            StFinish: begin
                state_d = StIdle;
                idx_d   = 2'd0;
            end

            default: begin
                state_d  = StIdle;
                idx_d    = 2'd0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge phi1) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            op_q        <= WOP_STORE;
            addr_q      <= '0;
            data_q      <= '0;
            pc_q        <= '0;
            status_q    <= '0;
            sp_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            sp_we_q     <= 1'b0;
            sp_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            pc_q        <= pc_d;
            status_q    <= status_d;
            sp_q        <= sp_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            sp_we_q     <= sp_we_d;
            sp_out_q    <= sp_out_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign sp_we         = sp_we_q;
    assign sp_out        = sp_out_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_stack_store_writer.sv
// tb_stack_store_writer
//   Bench for stack_store_writer. A transaction-level model turns each accepted request into
//   the list of (address, byte) writes and the final SP; a per-cycle monitor checks the bus,
//   busy, done, sp_we and sp_out against it. Directed cases pin the model with literal values.
module tb_stack_store_writer;

    logic        phi1 = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [15:0] addr_in = '0;
    logic [7:0]  data_in = '0;
    logic [15:0] pc_in = '0;
    logic [7:0]  status_in = '0;
    logic [7:0]  sp_in = '0;
    logic        busy, done, sp_we;
    logic [7:0]  sp_out;

    stack_store_writer_if bus ();

    stack_store_writer dut (
        .phi1      (phi1),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .pc_in     (pc_in),
        .status_in (status_in),
        .sp_in     (sp_in),
        .busy      (busy),
        .done      (done),
        .sp_out    (sp_out),
        .sp_we     (sp_we),
        .mem       (bus)
    );

    always #5 phi1 = ~phi1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state.
    logic [23:0] exp_q[$];   // {addr, data} still to be written
    logic [23:0] log_q[$];   // {addr, data} accepted by memory
    bit          pending = 0;
    bit          exp_push = 0;
    int          exp_n = 0;
    logic [7:0]  exp_sp_after = '0;
    logic [7:0]  model_sp = '0;
    bit          mon_en = 0;
    bit          we_next = 0;
    bit          lat_chk = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          done_cnt = 0;
    int          we_cycles = 0;
    int          stall_left = 0;
    bit          rand_ready = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge phi1) cyc++;

    // Memory side: ready tied high, randomly throttled, or forced low for a stall window.
    always @(posedge phi1) begin
        #2;
        if (stall_left > 0) begin
            bus.mem_ready = 1'b0;
            stall_left--;
        end else if (rand_ready) begin
            bus.mem_ready = ($urandom_range(0, 3) != 0);
        end else begin
            bus.mem_ready = 1'b1;
        end
    end

    // Expected writes of one request, from the addressing and byte-order rules.
    task automatic model_push(input logic [1:0] o, input logic [15:0] a, input logic [7:0] d,
                              input logic [15:0] pc, input logic [7:0] st,
                              input logic [7:0] sp);
        int n, spi, pci, ad, by;
        logic [15:0] ad16;
        logic [7:0]  by8;
        n   = (o == 2'd2) ? 2 : (o == 2'd3) ? 3 : 1;
        spi = int'(sp);
        pci = int'(pc);
        for (int k = 0; k < n; k++) begin
            ad = (o == 2'd0) ? int'(a) : 256 + ((spi - k + 256) % 256);
            if (o >= 2'd2) by = (k == 0) ? pci / 256 : (k == 1) ? pci % 256 : int'(st);
            else           by = int'(d);
            ad16 = ad[15:0];
            by8  = by[7:0];
            exp_q.push_back({ad16, by8});
        end
        exp_n        = n;
        exp_push     = (o != 2'd0);
        exp_sp_after = 8'((spi - n + 256) % 256);
    endtask

    always @(negedge phi1) begin
        if (mon_en) begin
            check("busy", busy, pending);
            if (we_next) check("we_held", bus.mem_we, 1);
            we_next = 1'b0;
            if (bus.mem_we) begin
                we_cycles++;
                if (exp_q.size() == 0) begin
                    check("write_expected", 0, 1);
                end else begin
                    check("mem_addr", bus.mem_addr, exp_q[0][23:8]);
                    check("mem_wdata", bus.mem_wdata, exp_q[0][7:0]);
                    if (bus.mem_ready) begin
                        log_q.push_back({bus.mem_addr, bus.mem_wdata});
                        void'(exp_q.pop_front());
                    end
                    we_next = !bus.mem_ready || (exp_q.size() != 0);
                end
            end
            if (done) begin
                check("done_expected", pending, 1);
                check("writes_left", exp_q.size(), 0);
                check("we_at_done", bus.mem_we, 0);
                check("sp_we_at_done", sp_we, exp_push);
                if (exp_push) model_sp = exp_sp_after;
                if (lat_chk) check("done_latency", cyc - accept_cyc, exp_n);
                done_cnt++;
                pending = 0;
            end else begin
                check("sp_we_quiet", sp_we, 0);
            end
            check("sp_out", sp_out, model_sp);
        end
    end

    task automatic apply_reset(input int cycles);
        @(posedge phi1);
        #1;
        reset_n = 1'b0;
        start   = 1'b0;
        @(posedge phi1);
        #1;
        exp_q.delete();
        pending    = 0;
        model_sp   = '0;
        we_next    = 0;
        lat_chk    = 0;
        stall_left = 0;
        mon_en     = 1;
        repeat (cycles - 1) @(posedge phi1);
        #1;
        reset_n = 1'b1;
        @(negedge phi1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_sp_we", sp_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_sp_out", sp_out, 0);
    endtask

    task automatic do_req(input logic [1:0] o, input logic [15:0] a, input logic [7:0] d,
                          input logic [15:0] pc, input logic [7:0] st, input logic [7:0] sp,
                          input int stall, input bit noise);
        int guard;
        guard = 0;
        @(negedge phi1);
        while (busy && guard < 2000) begin
            @(negedge phi1);
            guard++;
        end
        if (busy) begin
            check("idle_timeout", busy, 0);
            return;
        end
        op        = o;
        addr_in   = a;
        data_in   = d;
        pc_in     = pc;
        status_in = st;
        sp_in     = sp;
        start     = 1'b1;
        @(posedge phi1);
        #1;
        accept_cyc = cyc;
        model_push(o, a, d, pc, st, sp);
        pending    = 1;
        lat_chk    = (stall == 0) && !rand_ready;
        stall_left = stall;
        if (noise) begin
            // A second request while busy must be dropped.
            op        = 2'($urandom_range(0, 3));
            addr_in   = 16'($urandom);
            data_in   = 8'($urandom);
            pc_in     = 16'($urandom);
            status_in = 8'($urandom);
            sp_in     = 8'($urandom);
            @(posedge phi1);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && pending; i++) @(negedge phi1);
        @(negedge phi1);
        check("drain", pending, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, d0;
        bus.mem_ready = 1'b1;
        apply_reset(2);

        // Single store.
        log_q.delete();
        we_cycles = 0;
        d0 = done_cnt;
        do_req(2'd0, 16'h0200, 8'h5A, 16'h0000, 8'h00, 8'h33, 0, 0);
        drain();
        check("store_writes", log_q.size(), 1);
        check("store_w0", log_q[0], 24'h02005A);
        check("store_we_cycles", we_cycles, 1);
        check("store_done_cnt", done_cnt - d0, 1);

        // Return-address push.
        log_q.delete();
        do_req(2'd2, 16'h0000, 8'h00, 16'h1234, 8'h00, 8'hFD, 0, 0);
        drain();
        check("pushpc_writes", log_q.size(), 2);
        check("pushpc_w0", log_q[0], 24'h01FD12);
        check("pushpc_w1", log_q[1], 24'h01FC34);
        check("pushpc_sp", sp_out, 8'hFB);

        // Interrupt push crossing the page-1 wrap.
        log_q.delete();
        do_req(2'd3, 16'h0000, 8'h00, 16'hC003, 8'h34, 8'h01, 0, 0);
        drain();
        check("pushirq_writes", log_q.size(), 3);
        check("pushirq_w0", log_q[0], 24'h0101C0);
        check("pushirq_w1", log_q[1], 24'h010003);
        check("pushirq_w2", log_q[2], 24'h01FF34);
        check("pushirq_sp", sp_out, 8'hFE);

        // SP = 0 wraps to the top of page 1.
        log_q.delete();
        do_req(2'd2, 16'h0000, 8'h00, 16'hABCD, 8'h00, 8'h00, 0, 0);
        drain();
        check("wrap_w0", log_q[0], 24'h0100AB);
        check("wrap_w1", log_q[1], 24'h01FFCD);
        check("wrap_sp", sp_out, 8'hFE);

        // Single push held by three wait states.
        log_q.delete();
        we_cycles = 0;
        do_req(2'd1, 16'h0000, 8'hA5, 16'h0000, 8'h00, 8'hFF, 3, 0);
        drain();
        check("stall_we_cycles", we_cycles, 4);
        check("stall_writes", log_q.size(), 1);
        check("stall_w0", log_q[0], 24'h01FFA5);
        check("stall_sp", sp_out, 8'hFE);

        // Store into page 1 with a second start while busy.
        log_q.delete();
        d0 = done_cnt;
        do_req(2'd0, 16'h0150, 8'h77, 16'h0000, 8'h00, 8'h10, 0, 1);
        drain();
        check("noise_writes", log_q.size(), 1);
        check("noise_w0", log_q[0], 24'h015077);
        check("noise_done_cnt", done_cnt - d0, 1);
        check("noise_sp_hold", sp_out, 8'hFE);

        // Back-to-back stores: next accept n+2 edges after the first.
        do_req(2'd0, 16'h1000, 8'h01, 16'h0000, 8'h00, 8'h00, 0, 0);
        a0 = accept_cyc;
        do_req(2'd0, 16'h1001, 8'h02, 16'h0000, 8'h00, 8'h00, 0, 0);
        check("b2b_accept_gap", accept_cyc - a0, 3);
        drain();

        // Reset while the second byte of an interrupt push is on the bus.
        d0 = done_cnt;
        do_req(2'd3, 16'h0000, 8'h00, 16'h8765, 8'hB4, 8'h80, 0, 0);
        apply_reset(1);
        repeat (6) @(negedge phi1);
        check("abort_no_done", done_cnt - d0, 0);

        // Randomised traffic with throttled memory.
        rand_ready = 1;
        for (int t = 0; t < 150; t++) begin
            do_req(2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom), 16'($urandom),
                   8'($urandom), 8'($urandom),
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0,
                   ($urandom_range(0, 3) == 0));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stack_store_writer.md
Name: stack_store_writer

Overview:
- Write-side counterpart of the instruction fetcher: the fetcher initiates memory reads, this block sequences all CPU memory writes.
- Handles single-byte stores (STA/STX/STY), single-byte pushes (PHA/PHP) and multi-byte pushes (JSR return address; BRK/IRQ/NMI return address plus status).
- Owns stack-pointer arithmetic and the write handshake with the memory bus.
- Sits between the execute stage and the memory/bus mux.

Parameters:
- REG_WIDTH, 8, data and stack-pointer width
- ADDR_WIDTH, 16, memory address width
- STACK_BASE, 16'h0100, page added to SP to form the stack address

Ports:
- phi1  input  1  clock; all state changes on rising edge
- reset_n  input  1  reset, synchronous, active-low
- start  input  1  request strobe, sampled only in IDLE
- op  input  2  0=STORE, 1=PUSH1, 2=PUSH_PC, 3=PUSH_IRQ
- addr_in  input  16  target address for STORE
- data_in  input  8  byte for STORE/PUSH1
- pc_in  input  16  return address for PUSH_PC/PUSH_IRQ
- status_in  input  8  P register for PUSH_IRQ (caller sets B/bit5)
- sp_in  input  8  current stack pointer
- mem_ready  input  1  memory accepted current write this cycle
- busy  output  1  state != IDLE
- done  output  1  one-cycle completion pulse
- mem_we  output  1  write strobe
- mem_addr  output  16  write address
- mem_wdata  output  8  write data
- sp_out  output  8  updated stack pointer
- sp_we  output  1  one-cycle pulse, coincident with done, push ops only

Behaviour:
- States: IDLE, WRITE, FINISH. Byte counter idx (2 bits), byte count n: STORE=1, PUSH1=1, PUSH_PC=2, PUSH_IRQ=3.
- Reset (reset_n=0 at an edge) forces IDLE, idx=0, and busy=done=mem_we=sp_we=0. It also clears mem_addr, mem_wdata and sp_out to 0. This holds mid-operation: a partial push is abandoned, no sp_we is issued, and mem_we is low in the following cycle.
- IDLE + start=1: snapshot op, addr_in, data_in, pc_in, status_in and sp_in into internal registers, then go to WRITE with idx=0. Input changes after acceptance are ignored.
- start=1 in WRITE or FINISH: ignored, not queued.
- WRITE:
  - mem_we=1; mem_addr and mem_wdata are registered outputs.
  - Byte k of a push goes to STACK_BASE + ((sp - k) mod 256).
  - Bytes are pushed in the order PUSH_PC: PCH, PCL; PUSH_IRQ: PCH, PCL, P; PUSH1: data.
  - STORE: mem_addr = addr_in, with no SP involvement.
- mem_ready=0 in WRITE: hold the current address, data and mem_we unchanged (wait states are unlimited).
- mem_ready=1 in WRITE, not the last byte: advance idx; the next byte is driven in the next cycle. mem_we stays high across back-to-back bytes.
- mem_ready=1 in WRITE, last byte: go to FINISH with mem_we=0 and done=1.
  - Push ops: sp_we=1 and sp_out = (sp - n) mod 256.
  - STORE: sp_we=0 and sp_out holds its previous value.
- FINISH: lasts exactly one cycle, then returns to IDLE (done and sp_we are single-cycle pulses).
- Latency with mem_ready tied 1:
  - start sampled at edge E; first write visible in cycle E+1.
  - done in cycle E+n+1.
  - Earliest next start accepted at edge E+n+2.
- SP wrap: arithmetic is modulo 256.
  - sp=8'h00 pushing PCH, PCL writes to 16'h0100 and 16'h01FF; sp_out=8'hFE.
  - Stack address never leaves page 1.
- STORE to any address, including page 1, is a plain write.

Decomposition:
- Shared defines/package: REG_WIDTH, ADDR_WIDTH, STACK_BASE, the op encodings (WOP_STORE, WOP_PUSH1, WOP_PUSH_PC, WOP_PUSH_IRQ) and the state encodings.
- Single module, no sub-module. Byte selection (idx → PCH/PCL/P/data) is a local function inside the module.

Test Plan:
- STORE, addr_in=16'h0200, data_in=8'h5A, mem_ready=1 → exactly one cycle with mem_we=1, mem_addr=16'h0200, mem_wdata=8'h5A; done next cycle; sp_we=0.
- PUSH_PC, pc_in=16'h1234, sp_in=8'hFD → writes 8'h12@16'h01FD then 8'h34@16'h01FC; done with sp_we=1, sp_out=8'hFB.
- PUSH_IRQ, pc_in=16'hC003, status_in=8'h34, sp_in=8'h01 → writes 8'hC0@16'h0101, 8'h03@16'h0100, 8'h34@16'h01FF; sp_out=8'hFE.
- PUSH1 data_in=8'hA5 sp_in=8'hFF with mem_ready low for 3 cycles → address/data/we held stable for 4 cycles; single write; done after ready.
- start re-asserted during busy with different addr_in → ignored, original transaction completes unchanged, only one done.
- reset_n low during byte 2 of PUSH_IRQ → next cycle busy=0, mem_we=0; no done or sp_we ever pulses for that request.
